// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between REQUESTERS independent byte sources.
// Each requester holds Request_i[k] high with a stable byte on its Data_i slice
// until it sees its Ack_o[k] pulse. The arbiter picks one pending requester,
// issues a single-cycle start strobe plus the registered byte to the
// transmitter, then keeps that requester's grant until the transmitter reports
// frame completion on UartDone_i.
//
// Arbitration:
//   default build                   round-robin, search starts after last winner
//   UART_ARB_FIXED_PRIORITY_EN set  lowest set request index always wins
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-low reset
//   Request_i    in   [REQUESTERS]            level requests
//   Data_i       in   [REQUESTERS*DATA_WIDTH] requester k byte at k*DATA_WIDTH
//   Ack_o        out  [REQUESTERS]            one-cycle accept pulse
//   Grant_o      out  [REQUESTERS]            one-hot frame owner, 0 when idle
//   Busy_o       out  high while a frame is owned
//   UartStart_o  out  one-cycle start strobe to the transmitter
//   UartData_o   out  [DATA_WIDTH] byte to the transmitter, held until next start
//   UartBusy_i   in   transmitter busy flag (blocks a new start)
//   UartDone_i   in   transmitter one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int REQUESTERS = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                             Clock,
   input  logic                             Reset,
   input  logic [REQUESTERS-1:0]            Request_i,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] Data_i,
   output logic [REQUESTERS-1:0]            Ack_o,
   output logic [REQUESTERS-1:0]            Grant_o,
   output logic                             Busy_o,
   output logic                             UartStart_o,
   output logic [DATA_WIDTH-1:0]            UartData_o,
   input  logic                             UartBusy_i,
   input  logic                             UartDone_i
);

   localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   localparam logic [0:0] ST_IDLE      = 1'b0;
   localparam logic [0:0] ST_WAIT_DONE = 1'b1;

   logic [0:0]            state_reg;
   logic                  start_cycle_reg;   // high during the first WAIT_DONE cycle
   logic [IDX_W-1:0]      last_grant_reg;

   logic                  winner_valid;
   logic [IDX_W-1:0]      winner_idx;
   logic [REQUESTERS-1:0] winner_onehot;
   logic [DATA_WIDTH-1:0] req_data [REQUESTERS];

   // Unpack the flat data bus into one byte per requester.
   for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
      assign req_data[gi] = Data_i[gi*DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef UART_ARB_FIXED_PRIORITY_EN
   // Descending scan so the lowest set index is the last (winning) assignment.
   always_comb begin
      winner_valid = 1'b0;
      winner_idx   = '0;
      for (int i = REQUESTERS - 1; i >= 0; i--) begin
         if (Request_i[i]) begin
            winner_valid = 1'b1;
            winner_idx   = IDX_W'(i);
         end
      end
   end
`else
   int rr_cand;

   // Search last+1, last+2, ... wrapping; the last winner is visited last,
   // so a held request cannot be served again while another one is pending.
   always_comb begin
      winner_valid = 1'b0;
      winner_idx   = '0;
      rr_cand      = 0;
      for (int i = 1; i <= REQUESTERS; i++) begin
         rr_cand = int'(last_grant_reg) + i;
         if (rr_cand >= REQUESTERS) begin
            rr_cand = rr_cand - REQUESTERS;
         end
         if (!winner_valid && Request_i[IDX_W'(rr_cand)]) begin
            winner_valid = 1'b1;
            winner_idx   = IDX_W'(rr_cand);
         end
      end
   end
`endif

   always_comb begin
      winner_onehot             = '0;
      winner_onehot[winner_idx] = 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_reg       <= ST_IDLE;
         start_cycle_reg <= 1'b0;
         last_grant_reg  <= IDX_W'(REQUESTERS - 1);
         Ack_o           <= '0;
         Grant_o         <= '0;
         Busy_o          <= 1'b0;
         UartStart_o     <= 1'b0;
         UartData_o      <= '0;
      end else begin
         // Strobes default low so they last exactly one cycle.
         UartStart_o <= 1'b0;
         Ack_o       <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (winner_valid && !UartBusy_i) begin
                  state_reg       <= ST_WAIT_DONE;
                  start_cycle_reg <= 1'b1;
                  last_grant_reg  <= winner_idx;
                  UartData_o      <= req_data[winner_idx];
                  UartStart_o     <= 1'b1;
                  Ack_o           <= winner_onehot;
                  Grant_o         <= winner_onehot;
                  Busy_o          <= 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               start_cycle_reg <= 1'b0;
               // A done pulse in the start cycle belongs to no frame of ours.
               if (!start_cycle_reg && UartDone_i) begin
                  state_reg <= ST_IDLE;
                  Grant_o   <= '0;
                  Busy_o    <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               Grant_o   <= '0;
               Busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Scoreboard bench for uart_tx_arbiter (REQUESTERS=4, DATA_WIDTH=8).
// Requesters are modelled by issue/ack counters: Request_i[k] is high while
// requester k has bytes outstanding. A transmitter model answers each start
// with a fixed-length frame and a done pulse, and pops the expected
// (requester, byte) from the scoreboard to compare against the start.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N         = 4;
   localparam int DW        = 8;
   localparam int FRAME_LEN = 4;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [N-1:0]  Request_i;
   logic [N*DW-1:0] Data_i;
   logic [N-1:0]  Ack_o;
   logic [N-1:0]  Grant_o;
   logic          Busy_o;
   logic          UartStart_o;
   logic [DW-1:0] UartData_o;
   logic          UartBusy_i;
   logic          UartDone_i = 1'b0;

   logic          tx_busy = 1'b0;
   logic          busy_force = 1'b0;
   logic          spurious_done = 1'b0;
   int            req_total [N];
   int            ack_count [N];
   logic [DW-1:0] data_tbl  [N];

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   int tests_run    = 0;
   int tests_failed = 0;

   uart_tx_arbiter #(.REQUESTERS(N), .DATA_WIDTH(DW)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Request_i   (Request_i),
      .Data_i      (Data_i),
      .Ack_o       (Ack_o),
      .Grant_o     (Grant_o),
      .Busy_o      (Busy_o),
      .UartStart_o (UartStart_o),
      .UartData_o  (UartData_o),
      .UartBusy_i  (UartBusy_i),
      .UartDone_i  (UartDone_i)
   );

   always #5 Clock = ~Clock;

   for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign Request_i[gi]              = (req_total[gi] != ack_count[gi]);
      assign Data_i[gi*DW +: DW]        = data_tbl[gi];
   end
   assign UartBusy_i = tx_busy | busy_force;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int k);
      exp_t e;
      e.idx  = k;
      e.data = data_tbl[k];
      sb.push_back(e);
   endtask

   // Requesters retire a byte when they see their ack.
   always @(negedge Clock) begin
      for (int k = 0; k < N; k++) begin
         if (Ack_o[k]) ack_count[k] = ack_count[k] + 1;
      end
   end

   // Transmitter model and scoreboard consumer.
   always begin
      exp_t e;
      logic [N-1:0] oh;
      bit aborted;
      @(negedge Clock);
      if (Reset && UartStart_o) begin
         if (sb.size() == 0) begin
            check_value("unexpected_start", {24'd0, UartData_o}, 32'hFFFF_FFFF);
            e.idx = 0; e.data = '0;
         end else begin
            e = sb.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            check_value("start_ack", Ack_o, oh);
            check_value("start_grant", Grant_o, oh);
            check_value("start_data", UartData_o, e.data);
            check_value("start_busy", Busy_o, 1);
            $display("[TB] frame: requester %0d data %0h grant %0h", e.idx, UartData_o, Grant_o);
         end
         oh = '0;
         oh[e.idx] = 1'b1;
         tx_busy = 1'b1;
         aborted = 1'b0;
         if (spurious_done) UartDone_i = 1'b1;
         for (int c = 0; c < FRAME_LEN; c++) begin
            @(negedge Clock);
            UartDone_i = 1'b0;
            if (!Reset) begin
               aborted = 1'b1;
               break;
            end
            if (c == 0) begin
               check_value("start_pulse_len", UartStart_o, 0);
               check_value("ack_pulse_len", Ack_o, 0);
               if (spurious_done) check_value("done_in_start_ignored", Busy_o, 1);
            end
         end
         if (!aborted) begin
            UartDone_i = 1'b1;
            check_value("grant_held", Grant_o, oh);
            @(negedge Clock);
            UartDone_i = 1'b0;
            tx_busy    = 1'b0;
            if (Reset) begin
               check_value("grant_cleared", Grant_o, 0);
               check_value("busy_cleared", Busy_o, 0);
               check_value("no_early_start", UartStart_o, 0);
            end
         end else begin
            tx_busy = 1'b0;
         end
      end
   end

   task automatic wait_idle(input int max_cycles);
      bit ok = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         @(negedge Clock);
         if (sb.size() == 0 && !tx_busy && Request_i == '0 && !Busy_o) begin
            ok = 1'b1;
            break;
         end
      end
      check_value("drain_timeout", ok, 1);
   endtask

   task automatic apply_reset();
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
   endtask

   initial begin
      bit seen;
      for (int k = 0; k < N; k++) begin
         req_total[k] = 0;
         ack_count[k] = 0;
         data_tbl[k]  = '0;
      end
      Reset = 1'b0;
      #1;
      check_value("rst_ack", Ack_o, 0);
      check_value("rst_grant", Grant_o, 0);
      check_value("rst_busy", Busy_o, 0);
      check_value("rst_start", UartStart_o, 0);
      check_value("rst_data", UartData_o, 0);
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);

      // Single request: start and ack exactly one cycle after the sampling edge.
      data_tbl[0] = 8'hF0;
      push_exp(0);
      req_total[0] += 1;
      @(posedge Clock);
      #1;
      check_value("t1_latency_start", UartStart_o, 1);
      check_value("t1_latency_ack", Ack_o, 4'b0001);
      check_value("t1_grant", Grant_o, 4'b0001);
      check_value("t1_data", UartData_o, 8'hF0);
      wait_idle(100);
      check_value("t1_idle_grant", Grant_o, 0);

      // All four held: order 0,1,2,3,0; done pulses in start cycles are ignored.
      apply_reset();
      spurious_done = 1'b1;
      data_tbl[0] = 8'h31; data_tbl[1] = 8'h32; data_tbl[2] = 8'h33; data_tbl[3] = 8'h34;
      push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
      req_total[0] += 2; req_total[1] += 1; req_total[2] += 1; req_total[3] += 1;
      wait_idle(200);
      spurious_done = 1'b0;

      // Held requester 2 vs single request from 1, LastGrant=1: order 2,1,2.
      apply_reset();
      data_tbl[0] = 8'h41; data_tbl[1] = 8'h42; data_tbl[2] = 8'h43; data_tbl[3] = 8'h44;
      push_exp(1);
      req_total[1] += 1;
      wait_idle(100);
      push_exp(2); push_exp(1); push_exp(2);
      req_total[2] += 2;
      req_total[1] += 1;
      wait_idle(200);

      // Transmitter busy in IDLE blocks the start.
      busy_force = 1'b1;
      data_tbl[3] = 8'hA5;
      push_exp(3);
      req_total[3] += 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clock);
         check_value("blocked_start", UartStart_o, 0);
         check_value("blocked_grant", Grant_o, 0);
         check_value("blocked_busy", Busy_o, 0);
      end
      busy_force = 1'b0;
      wait_idle(100);

      // Reset in WAIT_DONE clears everything asynchronously.
      data_tbl[0] = 8'h51; data_tbl[1] = 8'h52; data_tbl[2] = 8'h53; data_tbl[3] = 8'h54;
      push_exp(0);
      req_total[0] += 1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clock);
         if (Busy_o) begin
            seen = 1'b1;
            break;
         end
      end
      check_value("t5_busy_seen", seen, 1);
      @(negedge Clock);
      #2;
      Reset = 1'b0;
      #1;
      check_value("t5_async_grant", Grant_o, 0);
      check_value("t5_async_busy", Busy_o, 0);
      check_value("t5_async_start", UartStart_o, 0);
      check_value("t5_async_ack", Ack_o, 0);
      check_value("t5_async_data", UartData_o, 0);
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      push_exp(0); push_exp(1); push_exp(2); push_exp(3);
      for (int k = 0; k < N; k++) req_total[k] += 1;
      wait_idle(200);

`ifdef UART_ARB_FIXED_PRIORITY_EN
      // Fixed priority: requester 1 wins every frame while held.
      apply_reset();
      data_tbl[1] = 8'h61; data_tbl[2] = 8'h62;
      push_exp(1); push_exp(1); push_exp(1); push_exp(2); push_exp(2); push_exp(2);
      req_total[1] += 3;
      req_total[2] += 3;
      wait_idle(300);
`endif

      check_value("sb_leftover", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between REQUESTERS independent byte sources.
- Accepts level-held byte requests and picks one by round-robin.
- Issues a single-cycle start plus the byte to the transmitter, then holds the grant until the transmitter reports frame completion.
- Sits between firmware/peripheral byte producers and the UART_TX instance, driving its Start_i/Data_i and observing its Busy_o/Done_o.

Parameters:
- REQUESTERS, 4, number of requester ports (2..16).
- DATA_WIDTH, 8, byte width passed to the transmitter.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Request_i  input  REQUESTERS  per-requester level request; requester holds it high, with data stable, until its Ack_o pulse.
- Data_i  input  REQUESTERS*DATA_WIDTH  requester k byte at [k*DATA_WIDTH +: DATA_WIDTH].
- Ack_o  output  REQUESTERS  one-cycle pulse: byte of requester k accepted.
- Grant_o  output  REQUESTERS  one-hot owner of the current frame, 0 when idle.
- Busy_o  output  1  high while a frame is owned (WAIT_DONE state).
- UartStart_o  output  1  one-cycle start strobe to the transmitter.
- UartData_o  output  DATA_WIDTH  registered byte to the transmitter; valid in the UartStart_o cycle and held until the next start.
- UartBusy_i  input  1  transmitter busy flag.
- UartDone_i  input  1  transmitter one-cycle frame-complete pulse.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State = IDLE.
  - Ack_o=0, Grant_o=0, Busy_o=0, UartStart_o=0, UartData_o=0.
  - LastGrant = REQUESTERS-1, so requester 0 has first priority.
- IDLE:
  - Move to WAIT_DONE when |Request_i and UartBusy_i=0 at a rising edge.
  - Winner k = first set request searching LastGrant+1, LastGrant+2, ... modulo REQUESTERS.
  - On that edge, register UartData_o <= byte k, UartStart_o <= 1, Ack_o[k] <= 1, Grant_o <= onehot(k), Busy_o <= 1, LastGrant <= k.
- Latency: request sampled at edge n gives UartStart_o and Ack_o high during cycle n+1.
- UartStart_o and Ack_o are high for exactly one cycle.
- WAIT_DONE:
  - UartDone_i is ignored in the first WAIT_DONE cycle, which is the start cycle.
  - After that, UartDone_i=1 returns to IDLE with Grant_o=0 and Busy_o=0.
  - Request_i changes are ignored in this state.
- Back-to-back: the next start comes no earlier than 2 cycles after the UartDone_i cycle (one IDLE evaluation edge).
- Requester k must deassert Request_i[k] in the cycle after Ack_o[k], or keep it high to queue another byte. A held request is re-arbitrated fairly, so k is served again only after all other pending requesters.
- A request dropped before the arbitration edge is not served.
- No request from the same requester is served twice while others are pending (round-robin fairness).
- UartBusy_i high in IDLE blocks the start; the arbiter stays in IDLE with all outputs 0.
- UartDone_i in IDLE is ignored.
- Reset mid-frame: immediate return to the reset values. The transmitter is reset by the same Reset.
- Single requester pending: served every frame with no idle gaps beyond the 1 IDLE cycle.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; the lowest set index of Request_i always wins. LastGrant is still tracked but unused. Starvation of high indices is allowed.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Reset release, Request_i=4'b0001 with byte 8'hF0 -> UartStart_o and Ack_o[0] pulse one cycle later, UartData_o=8'hF0, Grant_o=4'b0001 until UartDone_i, then Grant_o=0.
- All four requesters held high with bytes 8'h31, 8'h32, 8'h33, 8'h34 -> service order 0,1,2,3,0, each start only after the previous UartDone_i; Ack_o pulses are one-hot.
- Requester 2 holds its request continuously while requester 1 requests once -> order 2,1,2 when LastGrant=1 at start, showing no double service while another is pending.
- UartBusy_i=1 in IDLE with Request_i=4'b1000 -> no UartStart_o until UartBusy_i=0, then start with Grant_o=4'b1000.
- Reset driven low in WAIT_DONE -> all outputs 0 asynchronously; after release, Request_i=4'b1111 grants requester 0 first.
- UART_ARB_FIXED_PRIORITY_EN build, Request_i=4'b0110 held -> requester 1 wins every frame, requester 2 never granted.
